stream_endian_swapper: RTL and testbench
========================================

Name: stream_endian_swapper

Overview:
- Parametrised Avalon-ST endian swapper with CSR control.
- Sits inline on a packet stream between two Avalon-ST interfaces.
- Reorders data bytes in one of four selectable modes.
- The mode is latched per packet, so a CSR write never corrupts a packet in flight. The block also keeps packet, byte and protocol-error counters readable over Avalon-MM.

Parameters:
- DATA_BYTES, 8, stream width in bytes; power of two, minimum 4.
- EMPTY_W, $clog2(DATA_BYTES), width of the empty field (derived; do not override).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stream_in_data  in  DATA_BYTES*8  input beat data; byte 0 is bits [7:0].
- stream_in_empty  in  EMPTY_W  unused bytes in the final beat, counted from the low byte.
- stream_in_valid  in  1  input beat valid.
- stream_in_startofpacket  in  1  first beat of a packet.
- stream_in_endofpacket  in  1  last beat of a packet.
- stream_in_ready  out  1  block can accept a beat; readyLatency 0.
- stream_out_data  out  DATA_BYTES*8  swapped data.
- stream_out_empty  out  EMPTY_W  empty field, passed through unchanged.
- stream_out_valid  out  1  output beat valid.
- stream_out_startofpacket  out  1  first beat of a packet.
- stream_out_endofpacket  out  1  last beat of a packet.
- stream_out_ready  in  1  downstream can accept a beat.
- csr_address  in  2  CSR word address.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data.
- csr_readdatavalid  out  1  read data valid; fixed readLatency 1.
- csr_waitrequest  out  1  stall CSR access; high only while reset_n is low.

Behaviour:
- Reset values:
  - stream_out_valid=0, stream_out_data=0, stream_out_empty=0, stream_out_startofpacket=0, stream_out_endofpacket=0.
  - csr_readdata=0, csr_readdatavalid=0.
  - All counters 0, ctrl_mode=0, active_mode=0, in_packet=0.
- Stream handshake:
  - A beat is accepted when stream_in_valid & stream_in_ready.
  - stream_in_ready = !stream_out_valid | stream_out_ready (combinational).
  - Single output register stage: latency exactly 1 cycle from accept to stream_out_valid.
  - Output holds all fields stable while stream_out_valid & !stream_out_ready.
  - Full throughput of 1 beat per cycle under continuous ready.
- Swap modes (m = mode applied to the beat):
  - 0: pass-through.
  - 1: full byte reverse; out byte i = in byte DATA_BYTES-1-i.
  - 2: 16-bit halfword reverse; out halfword j = in halfword DATA_BYTES/2-1-j, bytes within each halfword unchanged.
  - 3: per-32-bit-lane byte reverse; each lane of 4 bytes reversed in place, lane order unchanged.
- Mode latching:
  - On an accepted SOP beat: active_mode <= ctrl_mode, and that beat itself uses ctrl_mode.
  - Non-SOP beats use active_mode.
  - A ctrl_mode write mid-packet takes effect from the next SOP.
- Packet tracking:
  - in_packet set on an accepted SOP and cleared on an accepted EOP.
  - A single-beat packet (SOP and EOP on the same beat) leaves in_packet=0.
- Counters (32-bit, wrap modulo 2^32):
  - packet_count: +1 per accepted SOP.
  - byte_count: +DATA_BYTES per accepted beat, or +(DATA_BYTES-empty) on an EOP beat.
  - error_count: +1 per accepted beat that is SOP while in_packet=1, or non-SOP while in_packet=0.
  - A beat raising both error conditions counts once.
  - On an error the beat still passes through.
  - An SOP-while-in_packet starts a new packet: packet_count increments and the mode is re-latched.
- CSR map:
  - Address 0, control: bits[1:0] ctrl_mode R/W. Bit 8 clear_counters: write-1 self-clearing, reads 0. Other bits read 0.
  - Address 1: packet_count, RO.
  - Address 2: byte_count, RO.
  - Address 3: error_count, RO.
  - Writes to RO addresses are ignored.
- CSR timing:
  - csr_readdatavalid pulses 1 cycle after csr_read, with csr_readdata valid that cycle.
  - Read and write asserted in the same cycle: the read is performed and the write is ignored.
- Simultaneous events: a counter clear and an increment in the same cycle resolve to 0 (clear wins).
- Reset mid-operation: asynchronous return to the reset values, mid-packet included; the first beat after reset is checked against in_packet=0.

Test Plan:
- Reset, write ctrl=1, send 3-beat packet of data 0x0706050403020100 with last-beat empty=2 -> output 0x0001020304050607 each beat, 1-cycle latency; packet_count=1, byte_count=22.
- Modes 2 and 3 on 0x0706050403020100 -> mode 2 gives 0x0100030205040706; mode 3 gives 0x0405060700010203.
- Write ctrl=0 after the first beat of a 4-beat packet in mode 1 -> all 4 beats byte-reversed; the next packet passes through unchanged.
- Hold stream_out_ready low 5 cycles mid-stream -> stream_in_ready low, output held stable, no beats lost or duplicated, order preserved.
- Protocol errors: SOP inside a packet, then a beat with no preceding SOP -> error_count=2, packet_count includes the extra SOP.
- Write 0x100 to address 0 while an SOP is accepted in the same cycle -> packet_count reads 0; the read returns with readdatavalid 1 cycle later.

Source files
------------

// File: rtl/stream_endian_swapper.sv
// Avalon-ST endian swapper: reorders bytes per packet-latched mode and keeps
// packet/byte/protocol-error counters readable over an Avalon-MM CSR port.
module stream_endian_swapper #(
  parameter int unsigned DATA_BYTES = 8,
  localparam int unsigned EMPTY_W = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_BYTES*8-1:0] stream_in_data,
  input  logic [EMPTY_W-1:0]      stream_in_empty,
  input  logic                    stream_in_valid,
  input  logic                    stream_in_startofpacket,
  input  logic                    stream_in_endofpacket,
  output logic                    stream_in_ready,
  output logic [DATA_BYTES*8-1:0] stream_out_data,
  output logic [EMPTY_W-1:0]      stream_out_empty,
  output logic                    stream_out_valid,
  output logic                    stream_out_startofpacket,
  output logic                    stream_out_endofpacket,
  input  logic                    stream_out_ready,
  input  logic [1:0]              csr_address,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [31:0]             csr_writedata,
  output logic [31:0]             csr_readdata,
  output logic                    csr_readdatavalid,
  output logic                    csr_waitrequest
);

  localparam int unsigned DATA_W = DATA_BYTES * 8;
  localparam int unsigned HALVES = DATA_BYTES / 2;

  localparam logic [1:0] MODE_BYTE = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;
  localparam logic [1:0] MODE_LANE = 2'd3;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_PKTS  = 2'd1;
  localparam logic [1:0] ADDR_BYTES = 2'd2;
  localparam logic [1:0] ADDR_ERRS  = 2'd3;

  logic [1:0]  ctrl_mode;
  logic [1:0]  active_mode;
  logic        in_packet;
  logic [31:0] packet_count;
  logic [31:0] byte_count;
  logic [31:0] error_count;

  logic        accept;
  logic [1:0]  beat_mode;
  logic        beat_err;
  logic [31:0] beat_bytes;
  logic        ctrl_write;
  logic        clear_counters;
  logic [31:0] read_mux;
  logic        unused_writedata;

  // Byte gather: each output byte selects its source byte for the given mode.
  function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [1:0] m);
    logic [DATA_W-1:0] r;
    int unsigned src;
    r = d;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      case (m)
        MODE_BYTE: src = DATA_BYTES - 1 - i;
        MODE_HALF: src = (HALVES - 1 - i / 2) * 2 + i % 2;
        MODE_LANE: src = (i / 4) * 4 + 3 - i % 4;
        default:   src = i;
      endcase
      r[i*8 +: 8] = d[src*8 +: 8];
    end
    return r;
  endfunction

  assign stream_in_ready = !stream_out_valid | stream_out_ready;
  assign accept          = stream_in_valid & stream_in_ready;
  assign beat_mode       = stream_in_startofpacket ? ctrl_mode : active_mode;
  assign beat_err        = stream_in_startofpacket ? in_packet : !in_packet;
  assign beat_bytes      = stream_in_endofpacket ? 32'(DATA_BYTES) - 32'(stream_in_empty)
                                                 : 32'(DATA_BYTES);

  // A read in the same cycle as a write wins; the write is dropped.
  assign ctrl_write      = csr_write & !csr_read & (csr_address == ADDR_CTRL);
  assign clear_counters  = ctrl_write & csr_writedata[8];
  assign csr_waitrequest = !reset_n;
  assign unused_writedata = ^{csr_writedata[31:9], csr_writedata[7:2]};

  always_comb begin
    read_mux = '0;
    case (csr_address)
      ADDR_CTRL:  read_mux = {30'd0, ctrl_mode};
      ADDR_PKTS:  read_mux = packet_count;
      ADDR_BYTES: read_mux = byte_count;
      ADDR_ERRS:  read_mux = error_count;
      default:    read_mux = '0;
    endcase
  end

  // Single output register stage; holds while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stream_out_valid         <= 1'b0;
      stream_out_data          <= '0;
      stream_out_empty         <= '0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
    end else if (stream_in_ready) begin
      stream_out_valid <= stream_in_valid;
      if (stream_in_valid) begin
        stream_out_data          <= swap_bytes(stream_in_data, beat_mode);
        stream_out_empty         <= stream_in_empty;
        stream_out_startofpacket <= stream_in_startofpacket;
        stream_out_endofpacket   <= stream_in_endofpacket;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_mode <= '0;
      in_packet   <= 1'b0;
    end else if (accept) begin
      if (stream_in_startofpacket) begin
        active_mode <= ctrl_mode;
      end
      if (stream_in_endofpacket) begin
        in_packet <= 1'b0;
      end else if (stream_in_startofpacket) begin
        in_packet <= 1'b1;
      end
    end
  end

  // Clear takes priority over any same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      packet_count <= '0;
      byte_count   <= '0;
      error_count  <= '0;
    end else if (clear_counters) begin
      packet_count <= '0;
      byte_count   <= '0;
      error_count  <= '0;
    end else if (accept) begin
      packet_count <= packet_count + 32'(stream_in_startofpacket);
      byte_count   <= byte_count + beat_bytes;
      error_count  <= error_count + 32'(beat_err);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_mode         <= '0;
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read) begin
        csr_readdata <= read_mux;
      end
      if (ctrl_write) begin
        ctrl_mode <= csr_writedata[1:0];
      end
    end
  end

endmodule

// File: tb/tb_stream_endian_swapper.sv
// Randomized bench for stream_endian_swapper: beats and CSR traffic are checked
// against a queue-based reference model of the swap, mode latching and counters.
module tb_stream_endian_swapper;

  localparam int unsigned DB = 8;
  localparam int unsigned EW = $clog2(DB);
  localparam int unsigned DW = DB * 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] stream_in_data;
  logic [EW-1:0] stream_in_empty;
  logic          stream_in_valid;
  logic          stream_in_startofpacket;
  logic          stream_in_endofpacket;
  logic          stream_in_ready;
  logic [DW-1:0] stream_out_data;
  logic [EW-1:0] stream_out_empty;
  logic          stream_out_valid;
  logic          stream_out_startofpacket;
  logic          stream_out_endofpacket;
  logic          stream_out_ready;
  logic [1:0]    csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [31:0]   csr_writedata;
  logic [31:0]   csr_readdata;
  logic          csr_readdatavalid;
  logic          csr_waitrequest;

  always #5 clk = ~clk;

  stream_endian_swapper #(.DATA_BYTES(DB)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_ready          (stream_in_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_ready         (stream_out_ready),
    .csr_address              (csr_address),
    .csr_read                 (csr_read),
    .csr_write                (csr_write),
    .csr_writedata            (csr_writedata),
    .csr_readdata             (csr_readdata),
    .csr_readdatavalid        (csr_readdatavalid),
    .csr_waitrequest          (csr_waitrequest)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t exp_q[$];
  beat_t out_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [1:0]  m_ctrl;
  logic [1:0]  m_active;
  logic        m_in_pkt;
  logic [31:0] m_pkt;
  logic [31:0] m_bytes;
  logic [31:0] m_errs;

  logic [31:0] rd;
  logic        rv;

  // Output monitor: one entry per completed output handshake.
  always @(negedge clk)
    if (reset_n && stream_out_valid && stream_out_ready)
      out_q.push_back({stream_out_data, stream_out_empty,
                       stream_out_startofpacket, stream_out_endofpacket});

  function automatic logic [DW-1:0] ref_swap(input logic [DW-1:0] d, input logic [1:0] mode);
    logic [DW-1:0] r;
    logic [31:0]   lane;
    r = d;
    case (mode)
      2'd1: r = {<<8{d}};
      2'd2: r = {<<16{d}};
      2'd3:
        for (int l = 0; l < int'(DB / 4); l++) begin
          lane = d[l*32 +: 32];
          r[l*32 +: 32] = {<<8{lane}};
        end
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic sop, input logic eop,
                              input logic [EW-1:0] emp);
    logic [1:0] mode;
    mode = sop ? m_ctrl : m_active;
    if ((sop && m_in_pkt) || (!sop && !m_in_pkt)) m_errs = m_errs + 32'd1;
    if (sop) begin
      m_active = m_ctrl;
      m_pkt    = m_pkt + 32'd1;
    end
    m_bytes = m_bytes + (eop ? 32'(DB) - 32'(emp) : 32'(DB));
    if (eop) m_in_pkt = 1'b0;
    else if (sop) m_in_pkt = 1'b1;
    exp_q.push_back({ref_swap(d, mode), emp, sop, eop});
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_active = '0; m_in_pkt = 1'b0;
    m_pkt = '0; m_bytes = '0; m_errs = '0;
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat until accepted; the model is updated at the accepting edge.
  task automatic drive_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                            input logic [EW-1:0] emp);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    stream_in_data = d; stream_in_startofpacket = sop; stream_in_endofpacket = eop;
    stream_in_empty = emp; stream_in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = stream_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    stream_in_valid = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL beat_accept: stream_in_ready stayed %b for %0d cycles, required 1", acc, n);
    end else begin
      model_accept(d, sop, eop, emp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] data);
    csr_address = a; csr_writedata = data; csr_write = 1'b1;
    @(posedge clk);
    #1;
    csr_write = 1'b0;
    if (a == 2'd0) begin
      m_ctrl = data[1:0];
      if (data[8]) begin m_pkt = '0; m_bytes = '0; m_errs = '0; end
    end
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] data, output logic valid);
    csr_address = a; csr_read = 1'b1;
    @(posedge clk);
    #1;
    csr_read = 1'b0;
    valid = csr_readdatavalid;
    data  = csr_readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stream_in_valid = 1'b0;
    model_reset();
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    idle(2);
    vectors++;
    if ({stream_out_valid, stream_out_data, stream_out_empty, stream_out_startofpacket,
         stream_out_endofpacket} !== '0) begin
      miscompares++;
      $display("FAIL reset_stream_out: got v=%b d=%h e=%0d s=%b e=%b, required all 0",
               stream_out_valid, stream_out_data, stream_out_empty,
               stream_out_startofpacket, stream_out_endofpacket);
    end
    vectors++;
    if (csr_readdata !== 32'd0 || csr_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_csr: got rd=%h rdv=%b, required 0/0", csr_readdata, csr_readdatavalid);
    end
    vectors++;
    if (csr_waitrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_waitrequest: got %b, required 1", csr_waitrequest);
    end
    reset_n = 1'b1;
    idle(1);
    vectors++;
    if (csr_waitrequest !== 1'b0 || stream_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: got waitrequest=%b in_ready=%b, required 0/1",
               csr_waitrequest, stream_in_ready);
    end
    for (int a = 0; a < 4; a++) begin
      csr_rd(2'(a), rd, rv);
      vectors++;
      if (rv !== 1'b1 || rd !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got rdv=%b data=%h, required 1/0", a, rv, rd);
      end
    end
  endtask

  task automatic test_mode1_packet();
    logic [DW-1:0] want;
    want = 64'h0001020304050607;
    csr_wr(2'd0, 32'd1);
    for (int b = 0; b < 3; b++) begin
      drive_beat(64'h0706050403020100, b == 0, b == 2, (b == 2) ? EW'(2) : EW'(0));
      vectors++;
      if (stream_out_valid !== 1'b1 || stream_out_data !== want) begin
        miscompares++;
        $display("FAIL mode1_latency beat%0d: got v=%b d=%h, required 1/%h",
                 b, stream_out_valid, stream_out_data, want);
      end
    end
    idle(2);
    vectors++;
    if (out_q.size() != 3 || out_q[2].empty !== EW'(2) || out_q[2].eop !== 1'b1) begin
      miscompares++;
      $display("FAIL mode1_stream: got %0d beats, required 3 with last empty=2 eop=1", out_q.size());
    end
    csr_rd(2'd1, rd, rv);
    vectors++;
    if (rv !== 1'b1 || rd !== 32'd1) begin
      miscompares++;
      $display("FAIL mode1_packet_count: got %0d, required 1", rd);
    end
    csr_rd(2'd2, rd, rv);
    vectors++;
    if (rv !== 1'b1 || rd !== 32'd22) begin
      miscompares++;
      $display("FAIL mode1_byte_count: got %0d, required 22", rd);
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_modes23();
    logic [DW-1:0] want [2];
    want[0] = 64'h0100030205040706;
    want[1] = 64'h0405060700010203;
    for (int m = 2; m < 4; m++) begin
      csr_wr(2'd0, 32'(m));
      drive_beat(64'h0706050403020100, 1'b1, 1'b1, '0);
      vectors++;
      if (stream_out_data !== want[m-2]) begin
        miscompares++;
        $display("FAIL mode%0d_data: got %h, required %h", m, stream_out_data, want[m-2]);
      end
    end
    idle(2);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL modes23_model beat%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_mode_change_midpacket();
    logic [DW-1:0] d;
    csr_wr(2'd0, 32'd1);
    d = {$urandom, $urandom};
    drive_beat(d, 1'b1, 1'b0, '0);
    csr_wr(2'd0, 32'd0);
    for (int b = 1; b < 4; b++) begin
      d = {$urandom, $urandom};
      drive_beat(d, 1'b0, b == 3, '0);
      vectors++;
      if (stream_out_data !== {<<8{d}}) begin
        miscompares++;
        $display("FAIL midpkt_mode beat%0d: got %h, required %h", b, stream_out_data, {<<8{d}});
      end
    end
    for (int b = 0; b < 2; b++) begin
      d = {$urandom, $urandom};
      drive_beat(d, b == 0, b == 1, '0);
      vectors++;
      if (stream_out_data !== d) begin
        miscompares++;
        $display("FAIL next_pkt_pass beat%0d: got %h, required %h", b, stream_out_data, d);
      end
    end
    idle(2);
    vectors++;
    if (out_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midpkt_count: got %0d beats, required %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midpkt_model beat%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t snap;
    csr_wr(2'd0, 32'd3);
    fork
      begin
        for (int b = 0; b < 8; b++) drive_beat({$urandom, $urandom}, b == 0, b == 7, '0);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        stream_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (c == 0) snap = {stream_out_data, stream_out_empty,
                              stream_out_startofpacket, stream_out_endofpacket};
          vectors++;
          if (stream_in_ready !== 1'b0 || stream_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ready c%0d: got in_ready=%b out_valid=%b, required 0/1",
                     c, stream_in_ready, stream_out_valid);
          end
          if (c > 0) begin
            vectors++;
            if ({stream_out_data, stream_out_empty, stream_out_startofpacket,
                 stream_out_endofpacket} !== snap) begin
              miscompares++;
              $display("FAIL stall_hold c%0d: got %h, required %h", c, stream_out_data, snap.data);
            end
          end
        end
        @(posedge clk);
        #2;
        stream_out_ready = 1'b1;
      end
    join
    idle(3);
    vectors++;
    if (out_q.size() != 8 || exp_q.size() != 8) begin
      miscompares++;
      $display("FAIL stall_count: got %0d beats, required 8", out_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_order beat%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_back_to_back();
    time t0;
    csr_wr(2'd0, 32'd2);
    t0 = $time;
    for (int b = 0; b < 16; b++) drive_beat({$urandom, $urandom}, b == 0, b == 15, EW'(b));
    vectors++;
    if ($time - t0 != 160) begin
      miscompares++;
      $display("FAIL b2b_throughput: got %0t for 16 beats, required 160", $time - t0);
    end
    idle(2);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_model beat%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_protocol_errors();
    csr_wr(2'd0, 32'h100);
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, '0);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, '0);
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, '0);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b1, EW'(3));
    drive_beat({$urandom, $urandom}, 1'b0, 1'b1, EW'(1));
    idle(2);
    csr_wr(2'd3, 32'hdead_beef);
    csr_rd(2'd3, rd, rv);
    vectors++;
    if (rv !== 1'b1 || rd !== 32'd2 || rd !== m_errs) begin
      miscompares++;
      $display("FAIL error_count: got %0d, required 2", rd);
    end
    csr_rd(2'd1, rd, rv);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL error_packet_count: got %0d, required 2", rd);
    end
    csr_rd(2'd2, rd, rv);
    vectors++;
    if (rd !== 32'd36) begin
      miscompares++;
      $display("FAIL error_byte_count: got %0d, required 36", rd);
    end
    vectors++;
    if (out_q.size() != 5) begin
      miscompares++;
      $display("FAIL error_passthrough: got %0d beats, required 5", out_q.size());
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_clear_race();
    logic [DW-1:0] d;
    csr_wr(2'd0, 32'd1);
    drive_beat({$urandom, $urandom}, 1'b1, 1'b1, '0);
    d = {$urandom, $urandom};
    stream_in_data = d; stream_in_startofpacket = 1'b1; stream_in_endofpacket = 1'b1;
    stream_in_empty = '0; stream_in_valid = 1'b1;
    csr_address = 2'd0; csr_writedata = 32'h100; csr_write = 1'b1;
    @(posedge clk);
    #1;
    stream_in_valid = 1'b0; csr_write = 1'b0;
    model_accept(d, 1'b1, 1'b1, '0);
    m_ctrl = '0; m_pkt = '0; m_bytes = '0; m_errs = '0;
    vectors++;
    if (stream_out_data !== {<<8{d}}) begin
      miscompares++;
      $display("FAIL clear_race_data: got %h, required %h", stream_out_data, {<<8{d}});
    end
    csr_address = 2'd1; csr_read = 1'b1;
    @(negedge clk);
    vectors++;
    if (csr_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rdv_early: got %b, required 0", csr_readdatavalid);
    end
    @(posedge clk);
    #1;
    csr_read = 1'b0;
    vectors++;
    if (csr_readdatavalid !== 1'b1 || csr_readdata !== m_pkt) begin
      miscompares++;
      $display("FAIL clear_race_packet_count: got rdv=%b %0d, required 1/0",
               csr_readdatavalid, csr_readdata);
    end
    idle(1);
    vectors++;
    if (csr_readdatavalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rdv_pulse: got %b, required 0", csr_readdatavalid);
    end
    csr_rd(2'd0, rd, rv);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL ctrl_readback: got %h, required 0", rd);
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_read_write_collision();
    csr_wr(2'd0, 32'd2);
    csr_address = 2'd0; csr_writedata = 32'd1; csr_read = 1'b1; csr_write = 1'b1;
    @(posedge clk);
    #1;
    csr_read = 1'b0; csr_write = 1'b0;
    vectors++;
    if (csr_readdatavalid !== 1'b1 || csr_readdata !== 32'd2) begin
      miscompares++;
      $display("FAIL rw_collision_read: got rdv=%b %h, required 1/2", csr_readdatavalid, csr_readdata);
    end
    csr_rd(2'd0, rd, rv);
    vectors++;
    if (rd !== 32'd2) begin
      miscompares++;
      $display("FAIL rw_collision_ctrl: got %h, required 2", rd);
    end
  endtask

  task automatic test_midpacket_reset();
    logic [DW-1:0] d;
    csr_wr(2'd0, 32'd1);
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, '0);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, '0);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (stream_out_valid !== 1'b0 || stream_out_data !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b d=%h, required 0/0", stream_out_valid, stream_out_data);
    end
    do_reset();
    d = {$urandom, $urandom};
    drive_beat(d, 1'b0, 1'b1, '0);
    idle(2);
    vectors++;
    if (out_q.size() != 1 || out_q[0] !== exp_q[0] || out_q[0].data !== d) begin
      miscompares++;
      $display("FAIL post_reset_beat: got %0d beats, required 1 pass-through of %h", out_q.size(), d);
    end
    csr_rd(2'd3, rd, rv);
    vectors++;
    if (rd !== 32'd1) begin
      miscompares++;
      $display("FAIL post_reset_error: got %0d, required 1", rd);
    end
    csr_rd(2'd1, rd, rv);
    vectors++;
    if (rd !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_packets: got %0d, required 0", rd);
    end
    exp_q.delete(); out_q.delete();
  endtask

  task automatic test_random();
    logic bp_done;
    int   len;
    bp_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          if ($urandom_range(0, 2) == 0) csr_wr(2'd0, 32'($urandom_range(0, 3)));
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            drive_beat({$urandom, $urandom}, b == 0, b == len - 1,
                       (b == len - 1) ? EW'($urandom_range(0, DB - 1)) : EW'(0));
          if ($urandom_range(0, 9) == 0)
            drive_beat({$urandom, $urandom}, 1'b0, 1'b1, '0);
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #2;
          stream_out_ready = ($urandom_range(0, 3) != 0);
        end
        stream_out_ready = 1'b1;
      end
    join
    idle(3);
    vectors++;
    if (out_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count: got %0d beats, required %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_beat%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      end
    end
    csr_rd(2'd1, rd, rv);
    vectors++;
    if (rd !== m_pkt) begin
      miscompares++;
      $display("FAIL random_packet_count: got %0d, required %0d", rd, m_pkt);
    end
    csr_rd(2'd2, rd, rv);
    vectors++;
    if (rd !== m_bytes) begin
      miscompares++;
      $display("FAIL random_byte_count: got %0d, required %0d", rd, m_bytes);
    end
    csr_rd(2'd3, rd, rv);
    vectors++;
    if (rd !== m_errs) begin
      miscompares++;
      $display("FAIL random_error_count: got %0d, required %0d", rd, m_errs);
    end
    exp_q.delete(); out_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    stream_in_data = '0; stream_in_empty = '0; stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
    stream_out_ready = 1'b1;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    #1;
    test_reset();
    test_mode1_packet();
    test_modes23();
    test_mode_change_midpacket();
    test_backpressure();
    test_back_to_back();
    test_protocol_errors();
    test_clear_race();
    test_read_write_collision();
    test_midpacket_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
